// File: rtl/riscv_shared_alu_arb_pkg.sv
// Shared-ALU arbiter definitions: ALU operator and vector-mode encodings
// matching the core's ALU, plus the packed per-requester request bundle.
package riscv_shared_alu_arb_pkg;

    localparam int unsigned ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADDU  = 7'b0011010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUBU  = 7'b0011011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 7'b0100100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 7'b0100101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 7'b0100111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS   = 7'b0000000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU   = 7'b0000001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LES   = 7'b0000100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LEU   = 7'b0000101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GTS   = 7'b0001000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GTU   = 7'b0001001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GES   = 7'b0001010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU   = 7'b0001011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ    = 7'b0001100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE    = 7'b0001101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS  = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU  = 7'b0000011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MIN   = 7'b0010000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MINU  = 7'b0010001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MAX   = 7'b0010010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MAXU  = 7'b0010011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ABS   = 7'b0010100;

    localparam logic [1:0] VEC_MODE32 = 2'b00;
    localparam logic [1:0] VEC_MODE16 = 2'b10;
    localparam logic [1:0] VEC_MODE8  = 2'b11;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0] operator;
        logic [31:0]             operand_a;
        logic [31:0]             operand_b;
        logic [1:0]              vector_mode;
    } alu_req_t;

    // Driven onto the ALU when nobody requests: a quiet, always-legal add.
    localparam alu_req_t ALU_REQ_IDLE = '{
        operator:    ALU_ADD,
        operand_a:   '0,
        operand_b:   '0,
        vector_mode: VEC_MODE32
    };

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_shared_alu_arb_rr.sv
// Combinational round-robin pick: first valid index at or after the pointer,
// wrapping past NUM_REQ-1 back to 0. The pointer register lives in the parent.
module riscv_rr_arb
    import riscv_shared_alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        w_found  = 1'b0;
        w_idx    = 0;
        o_winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Pointer is always < NUM_REQ, so a single subtract wraps correctly.
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && i_valid[w_idx]) begin
                w_found  = 1'b1;
                o_winner = ID_W'(w_idx);
            end
        end
        o_any = |i_valid;
    end

endmodule

// File: rtl/riscv_shared_alu_arb.sv
// Round-robin sharing of one ALU among NUM_REQ cores: operands go to the ALU
// combinationally, the result returns through one registered response stage.
module riscv_shared_alu_arb
    import riscv_shared_alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic [NUM_REQ-1:0]                     req_valid_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    input  logic [NUM_REQ-1:0][ALU_OP_WIDTH-1:0]   req_operator_i,
    input  logic [NUM_REQ-1:0][31:0]               req_operand_a_i,
    input  logic [NUM_REQ-1:0][31:0]               req_operand_b_i,
    input  logic [NUM_REQ-1:0][1:0]                req_vector_mode_i,

    output logic [NUM_REQ-1:0]                     resp_valid_o,
    input  logic [NUM_REQ-1:0]                     resp_ready_i,
    output logic [31:0]                            resp_result_o,
    output logic                                   resp_cmp_o,

    output logic [ALU_OP_WIDTH-1:0]                alu_operator_o,
    output logic [31:0]                            alu_operand_a_o,
    output logic [31:0]                            alu_operand_b_o,
    output logic [1:0]                             alu_vector_mode_o,
    input  logic [31:0]                            alu_result_i,
    input  logic                                   alu_cmp_i,
    input  logic                                   alu_ready_i
);

    logic [ID_W-1:0] r_ptr;
    logic            r_out_valid;
    logic [ID_W-1:0] r_out_id;
    logic [31:0]     r_out_result;
    logic            r_out_cmp;

    alu_req_t        w_req [NUM_REQ];
    alu_req_t        w_sel;
    logic [ID_W-1:0] w_winner;
    logic [ID_W-1:0] w_ptr_next;
    logic            w_any;
    logic            w_drain;
    logic            w_can_accept;
    logic            w_grant;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
        assign w_req[gi] = '{
            operator:    req_operator_i[gi],
            operand_a:   req_operand_a_i[gi],
            operand_b:   req_operand_b_i[gi],
            vector_mode: req_vector_mode_i[gi]
        };
    end

    riscv_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arb (
        .i_valid  (req_valid_i),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // A new op may enter only if the response slot is empty or drains now.
    assign w_drain      = r_out_valid & resp_ready_i[r_out_id];
    assign w_can_accept = alu_ready_i & (~r_out_valid | w_drain);
    assign w_grant      = w_can_accept & w_any & ~rst;

    assign w_ptr_next = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (w_grant) begin
            req_ready_o[w_winner] = 1'b1;
        end
    end

    assign w_sel             = w_any ? w_req[w_winner] : ALU_REQ_IDLE;
    assign alu_operator_o    = w_sel.operator;
    assign alu_operand_a_o   = w_sel.operand_a;
    assign alu_operand_b_o   = w_sel.operand_b;
    assign alu_vector_mode_o = w_sel.vector_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_out_valid  <= 1'b0;
            r_out_id     <= '0;
            r_out_result <= '0;
            r_out_cmp    <= 1'b0;
        end else if (w_grant) begin
            r_ptr        <= w_ptr_next;
            r_out_valid  <= 1'b1;
            r_out_id     <= w_winner;
            r_out_result <= alu_result_i;
            r_out_cmp    <= alu_cmp_i;
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_comb begin
        resp_valid_o = '0;
        if (r_out_valid) begin
            resp_valid_o[r_out_id] = 1'b1;
        end
    end

    assign resp_result_o = r_out_result;
    assign resp_cmp_o    = r_out_cmp;

    // Requesters must hold valid and operands until accepted.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_proto
        a_req_hold: assert property (
            @(posedge clk) disable iff (rst)
            (req_valid_i[gi] && !req_ready_o[gi]) |=>
                (req_valid_i[gi]
                 && $stable(req_operator_i[gi])
                 && $stable(req_operand_a_i[gi])
                 && $stable(req_operand_b_i[gi])
                 && $stable(req_vector_mode_i[gi]))
        );
    end

endmodule
